// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial receive path.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int DATA_WIDTH_DEF   = 4;
  localparam int CLKS_PER_BIT_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs; resets to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_nibble_receiver.sv
// UART-style deserialiser feeding an enable-loaded register: one Enable strobe
// per good frame, one FrameError pulse per bad parity or stop bit.
module serial_nibble_receiver
  import serial_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  SerialIn,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  Enable,
  output logic                  FrameError,
  output logic                  Busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  function automatic logic even_parity_mismatch(input logic [DATA_WIDTH-1:0] word,
                                                input logic                  pbit);
    return (^word) ^ pbit;
  endfunction

  logic                  s_line;
  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic                  load_q, load_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  enable_q;
  logic                  frame_err_q;
  logic                  busy_q;
  logic                  bit_done_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk_i (Clock),
    .rst_ni(Resetn),
    .d_i   (SerialIn),
    .q_o   (s_line)
  );

  assign bit_done_s = (cnt_q == BIT_LAST);

  // Frame FSM next-state: bit timing, payload capture, parity and stop checks
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    load_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s_line) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!s_line) begin
            state_d   = DATA;
            idx_d     = '0;
            par_err_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done_s) begin
          cnt_d          = '0;
          shift_d[idx_q] = s_line;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          cnt_d     = '0;
          par_err_d = even_parity_mismatch(shift_q, s_line);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A low stop bit may be a break; park until the line idles again
      STOP: begin
        if (bit_done_s) begin
          cnt_d = '0;
          if (s_line && !par_err_q) begin
            load_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_line ? IDLE : WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (s_line) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // FSM and datapath state
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      load_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      load_q    <= load_d;
      ferr_q    <= ferr_d;
    end
  end

  // Registered outputs; the word is published the cycle after the stop sample
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      data_q      <= '0;
      enable_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      enable_q    <= load_q;
      frame_err_q <= ferr_q;
      busy_q      <= (state_d != IDLE);
      if (load_q) begin
        data_q <= shift_q;
      end else begin
        data_q <= data_q;
      end
    end
  end

  assign Data       = data_q;
  assign Enable     = enable_q;
  assign FrameError = frame_err_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Directed and randomized frames checked against a frame-level timing model.
module tb_serial_nibble_receiver;

  localparam int DW  = 4;
  localparam int CPB = 4;
  localparam bit PEN = 1'b1;
  localparam int LAT = 2 + 1 + CPB / 2 + (DW + int'(PEN) + 1) * CPB + 1;
  localparam int FRAME_CYC = (1 + DW + int'(PEN) + 1) * CPB;

  logic          Clock    = 1'b0;
  logic          Resetn   = 1'b0;
  logic          SerialIn = 1'b1;
  logic [DW-1:0] Data;
  logic          Enable;
  logic          FrameError;
  logic          Busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int            en_cyc[$];
  logic [DW-1:0] en_data[$];
  int            fe_cyc[$];
  logic [DW-1:0] model_data;
  logic [DW-1:0] prev_data = '0;

  int            exp_c0[$];
  logic          exp_ok[$];
  logic [DW-1:0] exp_d[$];

  serial_nibble_receiver #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (PEN)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .SerialIn  (SerialIn),
    .Data      (Data),
    .Enable    (Enable),
    .FrameError(FrameError),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ok(input logic [DW-1:0] d, input logic p, input logic st);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return st && (!PEN || (int'(p) == ones % 2));
  endfunction

  function automatic logic even_bit(input logic [DW-1:0] d);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  // Output monitor: event capture, exclusivity and Data hold
  always @(negedge Clock) begin
    if (Resetn) begin
      if (Enable) begin
        en_cyc.push_back(cyc);
        en_data.push_back(Data);
      end
      if (FrameError) fe_cyc.push_back(cyc);
      chk("en_fe_exclusive", 32'(Enable & FrameError), 32'(0));
      if (!Enable) chk("data_hold", 32'(Data), 32'(prev_data));
    end
    prev_data = Data;
  end

  task automatic drive_bit(input logic b);
    SerialIn = b;
    repeat (CPB) @(posedge Clock);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic st,
                            output int c0);
    c0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PEN) drive_bit(pbit);
    drive_bit(st);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic expect_frame(input string tag, input int c0, input logic ok,
                              input logic [DW-1:0] d);
    if (ok) begin
      chk({tag, "_enable_seen"}, 32'(en_cyc.size() > 0), 32'(1));
      model_data = d;
      if (en_cyc.size() > 0) begin
        chk({tag, "_enable_latency"}, 32'(en_cyc[0] - c0), 32'(LAT));
        chk({tag, "_data"}, 32'(en_data[0]), 32'(model_data));
        void'(en_cyc.pop_front());
        void'(en_data.pop_front());
      end
    end else begin
      chk({tag, "_ferr_seen"}, 32'(fe_cyc.size() > 0), 32'(1));
      if (fe_cyc.size() > 0) begin
        chk({tag, "_ferr_latency"}, 32'(fe_cyc[0] - c0), 32'(LAT));
        void'(fe_cyc.pop_front());
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_no_extra_enable"}, 32'(en_cyc.size()), 32'(0));
    chk({tag, "_no_extra_ferr"}, 32'(fe_cyc.size()), 32'(0));
    en_cyc.delete();
    en_data.delete();
    fe_cyc.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"}, 32'(Data), 32'(0));
    chk({tag, "_enable"}, 32'(Enable), 32'(0));
    chk({tag, "_ferr"}, 32'(FrameError), 32'(0));
    chk({tag, "_busy"}, 32'(Busy), 32'(0));
  endtask

  initial begin
    int            c0;
    int            c1;
    int            gap;
    logic [DW-1:0] rd;
    logic          rp;
    logic          rs;

    model_data = '0;
    wait_cycles(3);
    check_outputs_zero("reset");
    Resetn = 1'b1;
    wait_cycles(4);
    check_outputs_zero("post_reset");

    // good frame 0xA
    send_frame(4'hA, even_bit(4'hA), 1'b1, c0);
    wait_cycles(12);
    expect_frame("t1", c0, model_ok(4'hA, even_bit(4'hA), 1'b1), 4'hA);
    check_quiet("t1");

    // bad parity on 0x7
    send_frame(4'h7, 1'b0, 1'b1, c0);
    wait_cycles(12);
    expect_frame("t2", c0, model_ok(4'h7, 1'b0, 1'b1), 4'h7);
    check_quiet("t2");
    chk("t2_data_kept", 32'(Data), 32'(model_data));

    // bad stop on 0x3 followed by a long break
    send_frame(4'h3, even_bit(4'h3), 1'b0, c0);
    wait_cycles(40);
    expect_frame("t3", c0, model_ok(4'h3, even_bit(4'h3), 1'b0), 4'h3);
    check_quiet("t3");
    chk("t3_busy_in_break", 32'(Busy), 32'(1));
    SerialIn = 1'b1;
    wait_cycles(6);
    chk("t3_busy_released", 32'(Busy), 32'(0));
    send_frame(4'h5, even_bit(4'h5), 1'b1, c0);
    wait_cycles(12);
    expect_frame("t3b", c0, 1'b1, 4'h5);
    check_quiet("t3b");

    // one-cycle glitch
    SerialIn = 1'b0;
    wait_cycles(1);
    SerialIn = 1'b1;
    wait_cycles(2);
    chk("t4_glitch_seen", 32'(Busy), 32'(1));
    wait_cycles(10);
    chk("t4_back_idle", 32'(Busy), 32'(0));
    check_quiet("t4");
    chk("t4_data_kept", 32'(Data), 32'(model_data));

    // back-to-back frames
    send_frame(4'h1, even_bit(4'h1), 1'b1, c0);
    send_frame(4'hE, even_bit(4'hE), 1'b1, c1);
    wait_cycles(12);
    if (en_cyc.size() == 2) chk("t5_spacing", 32'(en_cyc[1] - en_cyc[0]), 32'(FRAME_CYC));
    else chk("t5_two_enables", 32'(en_cyc.size()), 32'(2));
    expect_frame("t5a", c0, 1'b1, 4'h1);
    expect_frame("t5b", c1, 1'b1, 4'hE);
    check_quiet("t5");

    // reset during data bit 2 of 0xF
    c0 = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    SerialIn = 1'b1;
    wait_cycles(2);
    check_quiet("t6_pre");
    Resetn = 1'b0;
    #1;
    model_data = '0;
    check_outputs_zero("t6_reset");
    wait_cycles(3);
    Resetn = 1'b1;
    wait_cycles(3);
    check_quiet("t6_after");
    send_frame(4'h9, even_bit(4'h9), 1'b1, c0);
    wait_cycles(12);
    expect_frame("t6", c0, 1'b1, 4'h9);
    check_quiet("t6_end");

    // randomized frames with occasional parity/stop corruption
    for (int k = 0; k < 24; k++) begin
      rd  = DW'($urandom_range(0, (1 << DW) - 1));
      rp  = even_bit(rd) ^ ($urandom_range(0, 4) == 0);
      rs  = ($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs, c0);
      exp_c0.push_back(c0);
      exp_ok.push_back(model_ok(rd, rp, rs));
      exp_d.push_back(rd);
      gap = rs ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
      SerialIn = 1'b1;
      if (gap > 0) wait_cycles(gap);
    end
    wait_cycles(LAT);
    while (exp_c0.size() > 0) begin
      expect_frame("rand", exp_c0.pop_front(), exp_ok.pop_front(), exp_d.pop_front());
    end
    check_quiet("rand");
    chk("rand_final_data", 32'(Data), 32'(model_data));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
